// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the word-offset mask used to form word-aligned memory addresses.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] WORD_OFS_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // The reserved size code 2'b11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract with sign/zero extension, sub-word
// store merge, and misalignment detection (LSU_MISALIGN_TRAP_EN enables the trap).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        chk_addr_lo,
  input  logic [1:0]        chk_size,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [DATA_W-1:0] rdata,
  input  logic [15:0]       wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word,
  output logic              misaligned
);

  function automatic logic [DATA_W-1:0] ext8(input logic signed [7:0] v, input logic zext);
    return zext ? {{(DATA_W-8){1'b0}}, v} : {{(DATA_W-8){v[7]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic signed [15:0] v, input logic zext);
    return zext ? {{(DATA_W-16){1'b0}}, v} : {{(DATA_W-16){v[15]}}, v};
  endfunction

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Half accesses use addr[1] only, so an untrapped odd half address still hits a legal lane.
  always_comb begin
    byte_s     = rdata[{addr_lo, 3'b000} +: 8];
    half_s     = rdata[{addr_lo[1], 4'b0000} +: 16];
    load_data  = rdata;
    store_word = rdata;
    case (size)
      SZ_BYTE: begin
        load_data = ext8(byte_s, uns);
        store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = ext16(half_s, uns);
        store_word[{addr_lo[1], 4'b0000} +: 16] = wdata;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic [1:0] chk_sz_n;
  assign chk_sz_n   = norm_size(chk_size);
  assign misaligned = ((chk_sz_n == SZ_HALF) && chk_addr_lo[0]) ||
                      ((chk_sz_n == SZ_WORD) && ((chk_addr_lo & WORD_OFS_MASK) != 2'b00));
`else
  logic unused_chk;
  assign unused_chk = ^{chk_addr_lo, chk_size};
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit driving a word-wide memory; sub-word stores are read-modify-write.
// Misaligned accesses trap with resp_err only when LSU_MISALIGN_TRAP_EN is defined.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state, state_nxt;
  logic [1:0]        size_n, size_q, addr_lo_q;
  logic              we_q, uns_q, err_q;
  logic [15:0]       wdata_q;
  logic              accept, misaligned;
  logic [DATA_W-1:0] load_data, store_word;

  assign size_n = norm_size(req_size);
  assign accept = req_valid && (state == ST_IDLE);

  lsu_align u_align (
    .chk_addr_lo (req_addr[1:0]),
    .chk_size    (size_n),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .uns         (uns_q),
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word),
    .misaligned  (misaligned)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (misaligned)                         state_nxt = ST_RESP;
          else if (req_we && (size_n == SZ_WORD)) state_nxt = ST_WR;
          else                                    state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      size_q     <= SZ_BYTE;
      addr_lo_q  <= 2'b00;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        size_q    <= size_n;
        addr_lo_q <= req_addr[1:0];
        we_q      <= req_we;
        uns_q     <= req_unsigned;
        err_q     <= misaligned;
        wdata_q   <= req_wdata[15:0];
        mem_addr  <= {req_addr[ADDR_W-1:2], req_addr[1:0] & ~WORD_OFS_MASK};
        if (req_we && (size_n == SZ_WORD)) mem_wdata <= req_wdata;
      end
      // The RD cycle either finishes a load or supplies the word for the merge.
      if (state == ST_RD && we_q) mem_wdata <= store_word;
      if (state != ST_RESP && state_nxt == ST_RESP)
        resp_rdata <= (state == ST_RD) ? load_data : '0;
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign mem_read   = (state == ST_RD);
  assign mem_write  = (state == ST_WR);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = (state == ST_RESP) && err_q;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit on the initiator side of the data-memory interface. It accepts one load or store per handshake from the MEM pipeline stage and drives the word-wide data memory (mem_read/mem_write/addr/write_data, synchronous write, combinational read). Sub-word stores are done as a read-modify-write. Load data is extracted and sign- or zero-extended, and a one-cycle response is returned to the pipeline.

Parameters:
ADDR_W, 32, byte-address width of the request and the memory address.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline presents a request
req_ready  out  1  LSU can accept a request; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word
req_unsigned  in  1  loads only: zero-extend (1) or sign-extend (0)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores
resp_err  out  1  misaligned access; valid with resp_valid
mem_read  out  1  read strobe to data memory
mem_write  out  1  write strobe; memory writes on the rising edge
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid, resp_err, mem_read, mem_write=0; resp_rdata, mem_addr, mem_wdata=0. Reset is asynchronous: mem_write drops immediately and no partial write is issued.
- Accept: req_valid && req_ready at a rising edge. The edge latches addr, size, we, unsigned and wdata. req_ready is low from the next cycle until the cycle after resp_valid.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00.
- State machine (IDLE, RD, WR, RESP):
  - IDLE→RESP: misaligned; no memory strobe.
  - IDLE→RD: load, or store of byte/half.
  - IDLE→WR: word store.
  - RD: mem_read=1, mem_addr valid. mem_rdata is captured at the end of the cycle. Load→RESP. Sub-word store→WR.
  - WR: mem_write=1. mem_wdata is the captured word with the addressed byte/half lanes replaced by req_wdata[7:0] or [15:0]. Word store writes req_wdata directly. WR→RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - misaligned: 1 cycle
- Load extract:
  - byte lane addr[1:0], half lane addr[1].
  - Extended per req_unsigned, stored into resp_rdata at the RD edge.
  - resp_rdata holds until the next response.
- A new request can be accepted the cycle after RESP, giving back-to-back throughput of one op per 3–4 cycles. There is no response backpressure.
- mem_read and mem_write are never high together. Both are decoded from registered state only, so the outputs are glitch-free.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned access gets resp_err=1 and no memory access.
- Undefined:
  - low address bits are ignored: half uses addr[1], word uses lane 0.
  - the access proceeds normally.
  - resp_err is tied to 0.

Decomposition:
- lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - word-align mask constant
- Sub-module lsu_align (combinational):
  - load lane extract and sign/zero extend
  - store lane merge
  - misalign detect
- mem_lsu holds the FSM and the request/capture registers.

Test Plan:
- Reset: rst_n=0 mid-WR → mem_write=0 immediately; after release req_ready=1 and memory word unchanged.
- Word store then load: store 0x08 ← DEADBEEF.
  - store: resp_valid 2 cycles after accept, mem_write pulsed once.
  - then load word 0x08: resp_rdata=DEADBEEF at 2 cycles.
- Sub-word store, memory word 0x0C=11223344:
  - store byte 0x0D ← AB → word reads 1122AB44; exactly one mem_read then one mem_write, resp at 3 cycles.
  - store half 0x0E ← BEEF → word BEEFAB44.
- Extension, with word 0x10=80FF7F01:
  - signed byte 0x12 → FFFFFFFF
  - unsigned byte 0x12 → 000000FF
  - signed half 0x12 → FFFF80FF
  - signed byte 0x10 → 00000001
- Misalignment:
  - with LSU_MISALIGN_TRAP_EN, word load 0x0A → resp_err=1 at 1 cycle, no mem strobe.
  - without it → data of word 0x08, resp_err=0.
- Handshake: hold req_valid continuously for 3 loads → each accepted only when req_ready=1, one resp_valid pulse each, no dropped or duplicated requests.
